// File: rtl/pwm_multi_gen_if.sv
// Duty-write / PWM-status bundle for pwm_multi_gen.
// master: duty writer drives en/presc/wr_*/commit; slave: generator drives pwm_out/period_start/busy.
interface pwm_multi_gen_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                en;
  logic [PRESC_W-1:0]  presc;
  logic                wr_en;
  logic [CW-1:0]       wr_ch;
  logic [WIDTH-1:0]    wr_data;
  logic                commit;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_start;
  logic                busy;

  modport master (
    output en, presc, wr_en, wr_ch, wr_data, commit,
    input  pwm_out, period_start, busy
  );

  modport slave (
    input  en, presc, wr_en, wr_ch, wr_data, commit,
    output pwm_out, period_start, busy
  );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM with prescaler, shadow/active duties committed at wrap, optional stagger.
// Ports: clk, reset (sync, active-high), bus (slave modport: duty writes in, pwm/status out).
module pwm_multi_gen #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC_W  = 4,
  parameter int STAGGER  = 0
) (
  input  logic          clk,
  input  logic          reset,
  pwm_multi_gen_if.slave bus
);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SPAN = (2 ** WIDTH) / CHANNELS;
  localparam logic [CW:0] NCH = (CW + 1)'(CHANNELS);

  logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic                pending_q, pending_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                ps_q, ps_d;

  logic [WIDTH-1:0]    ph [CHANNELS];
  logic                tick;
  logic                wrap;
  logic                wr_ok;

  // Stagger offset advances the phase of channel k by k*SPAN ticks.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (STAGGER != 0)
        ph[k] = cnt_q + WIDTH'(k * SPAN);
      else
        ph[k] = cnt_q;
    end
  end

  always_comb begin
    // >= keeps a lowered presc from stalling the running count.
    tick  = bus.en && (presc_cnt_q >= bus.presc);
    wrap  = tick && (cnt_q == '1);
    wr_ok = bus.wr_en && ({1'b0, bus.wr_ch} < NCH);

    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_ok)
      shadow_d[bus.wr_ch] = bus.wr_data;

    // Transfer reads pre-write shadow so a same-cycle write waits for the next commit.
    pending_d = pending_q | bus.commit;
    if (wrap && pending_d) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    presc_cnt_d = '0;
    cnt_d       = '0;
    pwm_d       = '0;
    ps_d        = 1'b0;
    if (bus.en) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
      cnt_d       = tick ? cnt_q + 1'b1 : cnt_q;
      ps_d        = wrap;
      for (int k = 0; k < CHANNELS; k++) begin
        if (active_q[k] == '0)
          pwm_d[k] = 1'b0;
        else if (active_q[k] == '1)
          pwm_d[k] = 1'b1;
        else
          pwm_d[k] = ph[k] < active_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      pending_q   <= 1'b0;
      pwm_q       <= '0;
      ps_q        <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = ps_q;
  assign bus.busy         = pending_q;
endmodule
